// File: rtl/dll_lock_ctrl.sv
// dll_lock_ctrl: DLL acquisition/lock FSM steering a delay-line code from phase-detector votes.
// Optional DLL_LOCK_CTRL_FREEZE_EN adds a freeze input that holds the loop while locked.
module dll_lock_ctrl #(
  parameter int CODE_W  = 6,
  parameter int FILT_TH = 4,
  parameter int REV_N   = 4,
  parameter int LOSS_N  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [CODE_W-1:0] code_init,
  input  logic              pd_early,
  input  logic              pd_late,
`ifdef DLL_LOCK_CTRL_FREEZE_EN
  input  logic              freeze,
`endif
  output logic [CODE_W-1:0] code,
  output logic              locked,
  output logic [1:0]        state,
  output logic              err_sat
);
  localparam int RW = $clog2(REV_N + 1);
  localparam int LW = $clog2(LOSS_N + 1);
  localparam int AW = $clog2(FILT_TH + 1) + 1;
  localparam logic signed [AW-1:0] TH_P = AW'(FILT_TH);
  localparam logic signed [AW-1:0] TH_N = -TH_P;
  localparam logic signed [AW-1:0] A_P1 = AW'(1);
  localparam logic signed [AW-1:0] A_M1 = -A_P1;

  typedef enum logic [1:0] {IDLE, ACQ, LOCK, FAULT} st_t;

  st_t                    r_state, w_ns;
  logic [CODE_W-1:0]      r_code, w_code;
  logic                   r_locked, r_err, w_err;
  logic signed [AW-1:0]   r_acc, w_acc, w_sum;
  logic [RW-1:0]          r_rev, w_rev, w_rev_inc;
  logic [LW-1:0]          r_run, w_run, w_run_nx;
  logic                   r_dir, w_dir, r_dv, w_dv;
  logic                   w_up, w_dn, w_sat, w_frz;

  assign w_up      = pd_early & ~pd_late;
  assign w_dn      = pd_late & ~pd_early;
  assign w_sat     = (w_up && r_code == '1) || (w_dn && r_code == '0);
  assign w_sum     = r_acc + (w_up ? A_P1 : A_M1);
  assign w_rev_inc = r_rev + RW'(1);
  // run length restarts at 1 on the first step after entry or on a direction change
  assign w_run_nx  = (r_dv && r_dir == w_up) ? r_run + LW'(1) : LW'(1);
`ifdef DLL_LOCK_CTRL_FREEZE_EN
  assign w_frz = freeze;
`else
  assign w_frz = 1'b0;
`endif

  always_comb begin
    w_ns   = r_state;
    w_code = r_code;
    w_err  = r_err;
    w_acc  = r_acc;
    w_rev  = r_rev;
    w_run  = r_run;
    w_dir  = r_dir;
    w_dv   = r_dv;
    if (ena && start) begin
      w_ns   = ACQ;
      w_code = code_init;
      w_err  = 1'b0;
      w_acc  = '0;
      w_rev  = '0;
      w_run  = '0;
      w_dv   = 1'b0;
    end else if (ena) begin
      case (r_state)
        ACQ: if (w_up || w_dn) begin
          if (w_sat) begin
            w_ns  = FAULT;
            w_err = 1'b1;
          end else begin
            w_code = w_up ? r_code + 1'b1 : r_code - 1'b1;
            w_dir  = w_up;
            w_dv   = 1'b1;
            if (r_dv && r_dir != w_up) begin
              w_rev = w_rev_inc;
              if (w_rev_inc == RW'(REV_N)) begin
                w_ns  = LOCK;
                w_rev = '0;
                w_run = '0;
                w_acc = '0;
                w_dv  = 1'b0;
              end
            end
          end
        end
        LOCK: if (!w_frz && (w_up || w_dn)) begin
          if (w_sum != TH_P && w_sum != TH_N) begin
            w_acc = w_sum;
          end else if (w_sat) begin
            w_ns  = FAULT;
            w_err = 1'b1;
            w_acc = '0;
          end else begin
            w_code = w_up ? r_code + 1'b1 : r_code - 1'b1;
            w_acc  = '0;
            w_dir  = w_up;
            w_dv   = 1'b1;
            w_run  = w_run_nx;
            if (w_run_nx == LW'(LOSS_N)) begin
              w_ns  = ACQ;
              w_run = '0;
              w_rev = '0;
              w_dv  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_code   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_acc    <= '0;
      r_rev    <= '0;
      r_run    <= '0;
      r_dir    <= 1'b0;
      r_dv     <= 1'b0;
    end else begin
      r_state  <= w_ns;
      r_code   <= w_code;
      r_locked <= (w_ns == LOCK);
      r_err    <= w_err;
      r_acc    <= w_acc;
      r_rev    <= w_rev;
      r_run    <= w_run;
      r_dir    <= w_dir;
      r_dv     <= w_dv;
    end
  end

  assign code    = r_code;
  assign locked  = r_locked;
  assign state   = r_state;
  assign err_sat = r_err;
endmodule

// File: tb/tb_dll_lock_ctrl.sv
// tb_dll_lock_ctrl: directed vector table plus hand sequences for dll_lock_ctrl.
module tb_dll_lock_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, ena, start, pd_early, pd_late, freeze;
  logic [5:0] code_init, code;
  logic       locked, err_sat;
  logic [1:0] state;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic       en, st;
    logic [5:0] ci;
    logic       e, l;
    logic [5:0] c;
    logic [1:0] s;
    logic       lk, er;
  } vec_t;
  vec_t v[$];

  always #5 clk = ~clk;

  dll_lock_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(start),
    .code_init(code_init),
    .pd_early(pd_early),
    .pd_late(pd_late),
`ifdef DLL_LOCK_CTRL_FREEZE_EN
    .freeze(freeze),
`endif
    .code(code),
    .locked(locked),
    .state(state),
    .err_sat(err_sat)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [5:0] c, input logic [1:0] s, input logic lk, input logic er);
    cmp({nm, ".code"}, int'(code), int'(c));
    cmp({nm, ".state"}, int'(state), int'(s));
    cmp({nm, ".locked"}, int'(locked), int'(lk));
    cmp({nm, ".err_sat"}, int'(err_sat), int'(er));
  endtask

  task automatic drive(input logic en, input logic st, input logic [5:0] ci, input logic e, input logic l);
    @(negedge clk);
    ena = en; start = st; code_init = ci; pd_early = e; pd_late = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic add(input logic en, st, input logic [5:0] ci, input logic e, l,
                     input logic [5:0] c, input logic [1:0] s, input logic lk, er);
    vec_t t;
    t.en = en; t.st = st; t.ci = ci; t.e = e; t.l = l;
    t.c = c; t.s = s; t.lk = lk; t.er = er;
    v.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; code_init = '0;
    pd_early = 1'b0; pd_late = 1'b0; freeze = 1'b0;
    // en st ci  e l   code st lk er
    add(1, 0,  0, 1, 0,  0, 0, 0, 0);
    add(1, 1, 32, 0, 0, 32, 1, 0, 0);
    add(1, 0,  0, 1, 0, 33, 1, 0, 0);
    add(1, 1, 32, 1, 0, 32, 1, 0, 0);
    add(1, 0,  0, 1, 0, 33, 1, 0, 0);
    add(1, 0,  0, 0, 1, 32, 1, 0, 0);
    add(1, 0,  0, 1, 0, 33, 1, 0, 0);
    add(1, 0,  0, 0, 1, 32, 1, 0, 0);
    add(1, 0,  0, 1, 0, 33, 2, 1, 0);
    add(1, 0,  0, 1, 0, 33, 2, 1, 0);
    add(1, 0,  0, 1, 0, 33, 2, 1, 0);
    add(0, 0,  0, 1, 0, 33, 2, 1, 0);
    add(1, 0,  0, 1, 0, 33, 2, 1, 0);
    add(1, 0,  0, 1, 0, 34, 2, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 34, 2, 1, 0);
    add(1, 0,  0, 1, 0, 35, 2, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 35, 2, 1, 0);
    add(1, 0,  0, 1, 0, 36, 1, 0, 0);
    add(1, 0,  0, 1, 1, 36, 1, 0, 0);
    add(0, 1,  5, 1, 0, 36, 1, 0, 0);
    add(1, 1, 63, 0, 0, 63, 1, 0, 0);
    add(1, 0,  0, 1, 0, 63, 3, 0, 1);
    add(1, 0,  0, 0, 1, 63, 3, 0, 1);
    add(1, 1, 10, 0, 0, 10, 1, 0, 0);
    add(1, 1,  0, 0, 0,  0, 1, 0, 0);
    add(1, 0,  0, 0, 1,  0, 3, 0, 1);
    add(1, 1,  1, 0, 0,  1, 1, 0, 0);
    add(1, 0,  0, 0, 1,  0, 1, 0, 0);
    add(1, 0,  0, 1, 0,  1, 1, 0, 0);
    add(0, 0,  0, 1, 0,  1, 1, 0, 0);
    add(1, 0,  0, 0, 1,  0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1 chk("reset_hold", 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].en, v[i].st, v[i].ci, v[i].e, v[i].l);
      chk($sformatf("vec%0d", i), v[i].c, v[i].s, v[i].lk, v[i].er);
    end

    drive(1, 1, 20, 0, 0);
    chk("pre_async", 20, 1, 0, 0);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    drive(1, 0, 0, 1, 0);
    chk("idle_after_rst", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    chk("idle_after_rst2", 0, 0, 0, 0);

`ifdef DLL_LOCK_CTRL_FREEZE_EN
    drive(1, 1, 32, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, i % 2 == 0, i % 2 == 1);
    chk("frz_lock", 33, 2, 1, 0);
    @(negedge clk) freeze = 1'b1;
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 1, 0);
    chk("frz_hold", 33, 2, 1, 0);
    @(negedge clk) freeze = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 0);
    chk("frz_release", 34, 2, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dll_lock_ctrl.md
DLL_LOCK_CTRL -- requirements
Module: dll_lock_ctrl

Interface
REQ-001 CODE_W, default 6: delay-line control code width; code range 0 to 2^CODE_W-1.
REQ-002 FILT_TH, default 4: LOCK-state loop-filter threshold, in net phase-detector votes per code step.
REQ-003 REV_N, default 4: direction reversals in ACQ required to declare lock.
REQ-004 LOSS_N, default 3: consecutive same-direction code steps in LOCK that declare loss of lock.
REQ-005 clk  in  1  single block clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 ena  in  1  loop enable; 0 freezes all state and ignores start.
REQ-008 start  in  1  single-cycle pulse that begins acquisition from code_init.
REQ-009 code_init  in  CODE_W  code loaded when start is accepted.
REQ-010 pd_early  in  1  phase-detector vote: delay too short; requests an increase in code.
REQ-011 pd_late  in  1  phase-detector vote: delay too long; requests a decrease in code.
REQ-012 code  out  CODE_W  registered delay-line code.
REQ-013 locked  out  1  registered; 1 only in state LOCK.
REQ-014 state  out  2  registered FSM state: IDLE=0, ACQ=1, LOCK=2, FAULT=3.
REQ-015 err_sat  out  1  sticky saturation flag.

Function
REQ-016 Vote decode: early&!late = up; late&!early = down; both set or neither set = no-op.
REQ-017 Accepted start (ena=1) takes priority over all other events in every state.
REQ-018 On accepted start, next edge: code=code_init, state=ACQ, filter/counters=0, err_sat=0.
REQ-019 IDLE: code holds; votes are ignored.
REQ-020 ACQ: each up/down vote changes code by +1/-1 on the next edge (1-cycle latency).
REQ-021 ACQ: a step opposite in direction to the previous step counts one reversal; the first step after entry never counts.
REQ-022 ACQ: on the edge where the reversal count reaches REV_N, that step is applied, state becomes LOCK and locked becomes 1.
REQ-023 LOCK: a signed accumulator counts up votes +1 and down votes -1.
REQ-024 LOCK: when the accumulator would reach +FILT_TH, code increments by 1 and the accumulator clears; at -FILT_TH, code decrements by 1 and the accumulator clears.
REQ-025 LOCK: a code step in the same direction as the previous step increments the run counter; an opposite-direction step sets the run counter to 1.
REQ-026 LOCK: when the run counter reaches LOSS_N, that step is applied, state becomes ACQ and locked becomes 0; the accumulator, reversal count and run counter clear.
REQ-027 Saturation: an up vote (ACQ) or up step (LOCK) at code=2^CODE_W-1, or a down vote or step at code=0, leaves code unchanged and sets err_sat=1, state=FAULT, locked=0.
REQ-028 FAULT: code holds; votes are ignored; only an accepted start or reset exits FAULT.
REQ-029 ena=0: every register holds its value, including in the middle of an ACQ or LOCK sequence; operation resumes unchanged when ena returns to 1.

Reset
REQ-030 rst_n=0 immediately forces code=0, state=IDLE, locked=0, err_sat=0, and clears the accumulator and all counters, regardless of clk.
REQ-031 Reset deassertion has no effect until the next rising clk edge; after deassertion the block stays in IDLE until an accepted start.

Configuration
REQ-032 Macro DLL_LOCK_CTRL_FREEZE_EN, when defined, adds input port freeze (1 bit).
REQ-033 With DLL_LOCK_CTRL_FREEZE_EN defined, freeze=1 in LOCK holds the code, accumulator and run counter, and keeps locked=1.
REQ-034 With DLL_LOCK_CTRL_FREEZE_EN undefined, the freeze port is absent and behaviour is exactly as in REQ-016 to REQ-029.

Verification
REQ-035 Assert rst_n=0 in the middle of a clock cycle -> code=0, state=0, locked=0, err_sat=0 immediately.
REQ-036 start with code_init=32, then a single early vote -> code=33, state=1.
REQ-037 From code=32 in ACQ, alternate early/late votes over 5 cycles -> codes 33,32,33,32,33; state=2 and locked=1 on the fifth edge.
REQ-038 In LOCK at code=33: 4 early votes -> code=34 after the fourth; 12 consecutive early votes -> code=36 and state=1, locked=0 after the twelfth.
REQ-039 start with code_init=63, then an early vote -> code=63, err_sat=1, state=3; then start with code_init=10 -> code=10, state=1, err_sat=0.
REQ-040 With DLL_LOCK_CTRL_FREEZE_EN defined: in LOCK, freeze=1 plus 20 early votes -> code unchanged and locked=1.
